// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX-stage result select, EX/MEM pipeline register, the HI/LO
// register pair and a sequential 32-step shift-add unsigned multiplier (MULTU)
// that holds EX while it runs.
//
// Multiplier FSM states:
//   state | meaning
//   IDLE  | no multiply in flight; a valid MULTU in EX starts one
//   BUSY  | one shift-add iteration per cycle, 32 iterations total
//   DONE  | product ready; HI/LO written on the first edge without mem_stall

module ex_mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [1:0]  ex_sel,
    input  logic        ex_multu,
    input  logic [31:0] alu_result,
    input  logic [31:0] sht_result,
    input  logic [31:0] mul_a,
    input  logic [31:0] mul_b,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic [31:0] ex_store_data,
    input  logic        mem_stall,
    input  logic        flush,
    output logic        stall_ex,
    output logic        mem_valid,
    output logic        mem_regwrite,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic [31:0] mem_result,
    output logic [31:0] mem_store_data,
    output logic [4:0]  mem_rd,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_SHT = 2'd1;
    localparam logic [1:0] SEL_HI  = 2'd2;
    localparam logic [1:0] SEL_LO  = 2'd3;

    localparam logic [4:0] LAST_ITER = 5'd31;

    mul_state_t  state_q, state_d;

    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        mem_valid_q, mem_valid_d;
    logic        mem_regwrite_q, mem_regwrite_d;
    logic        mem_memread_q, mem_memread_d;
    logic        mem_memwrite_q, mem_memwrite_d;
    logic [31:0] mem_result_q, mem_result_d;
    logic [31:0] mem_store_data_q, mem_store_data_d;
    logic [4:0]  mem_rd_q, mem_rd_d;

    logic        mul_req;
    logic        mul_start;
    logic        mul_step;
    logic        mul_commit;
    logic [32:0] add_sum;
    logic [31:0] ex_result;

    assign mul_req = ex_valid & ex_multu;

    // Multiplier state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Multiplier next-state logic; flush abandons any multiply in flight
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (mul_req)              state_d = ST_BUSY;
                ST_BUSY: if (count_q == LAST_ITER) state_d = ST_DONE;
                ST_DONE: if (!mem_stall)           state_d = ST_IDLE;
                default:                           state_d = ST_IDLE;
            endcase
        end
    end

    // Multiplier outputs: EX stall plus start/step/commit strobes for the datapath
    always_comb begin
        stall_ex   = mul_req & (state_q != ST_DONE);
        mul_start  = 1'b0;
        mul_step   = 1'b0;
        mul_commit = 1'b0;
        if (!flush) begin
            case (state_q)
                ST_IDLE: mul_start  = mul_req;
                ST_BUSY: mul_step   = 1'b1;
                ST_DONE: mul_commit = ~mem_stall;
                default: ;
            endcase
        end
    end

    // Shift-add iteration: add multiplicand to the upper half, then shift
    // {carry, accumulator} right so the carry lands in bit 63
    always_comb begin
        add_sum  = {1'b0, acc_q[63:32]} + {1'b0, (mplier_q[0] ? mcand_q : 32'd0)};
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        if (mul_start) begin
            mcand_d  = mul_a;
            mplier_d = mul_b;
            acc_d    = 64'd0;
            count_d  = 5'd0;
        end else if (mul_step) begin
            acc_d    = {add_sum, acc_q[31:1]};
            mplier_d = {1'b0, mplier_q[31:1]};
            count_d  = count_q + 5'd1;
        end
    end

    // HI/LO change only on the DONE exit edge, so a flushed multiply leaves them intact
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (mul_commit) begin
            hi_d = acc_q[63:32];
            lo_d = acc_q[31:0];
        end
    end

    // Multiplier datapath and HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            count_q  <= 5'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // EX result select; MFHI/MFLO read the architectural registers directly
    always_comb begin
        case (ex_sel)
            SEL_ALU: ex_result = alu_result;
            SEL_SHT: ex_result = sht_result;
            SEL_HI:  ex_result = hi_q;
            SEL_LO:  ex_result = lo_q;
            default: ex_result = alu_result;
        endcase
    end

    // EX/MEM register update: flush, then hold on mem_stall, then bubble on stall_ex.
    // Data fields are left alone on flush/bubble; only valid and control matter there.
    always_comb begin
        mem_valid_d      = mem_valid_q;
        mem_regwrite_d   = mem_regwrite_q;
        mem_memread_d    = mem_memread_q;
        mem_memwrite_d   = mem_memwrite_q;
        mem_result_d     = mem_result_q;
        mem_store_data_d = mem_store_data_q;
        mem_rd_d         = mem_rd_q;
        if (flush || (!mem_stall && stall_ex)) begin
            mem_valid_d    = 1'b0;
            mem_regwrite_d = 1'b0;
            mem_memread_d  = 1'b0;
            mem_memwrite_d = 1'b0;
        end else if (!mem_stall) begin
            mem_valid_d      = ex_valid;
            mem_regwrite_d   = ex_regwrite & ex_valid;
            mem_memread_d    = ex_memread & ex_valid;
            mem_memwrite_d   = ex_memwrite & ex_valid;
            mem_result_d     = ex_result;
            mem_store_data_d = ex_store_data;
            mem_rd_d         = ex_rd;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid_q      <= 1'b0;
            mem_regwrite_q   <= 1'b0;
            mem_memread_q    <= 1'b0;
            mem_memwrite_q   <= 1'b0;
            mem_result_q     <= 32'd0;
            mem_store_data_q <= 32'd0;
            mem_rd_q         <= 5'd0;
        end else begin
            mem_valid_q      <= mem_valid_d;
            mem_regwrite_q   <= mem_regwrite_d;
            mem_memread_q    <= mem_memread_d;
            mem_memwrite_q   <= mem_memwrite_d;
            mem_result_q     <= mem_result_d;
            mem_store_data_q <= mem_store_data_d;
            mem_rd_q         <= mem_rd_d;
        end
    end

    assign mem_valid      = mem_valid_q;
    assign mem_regwrite   = mem_regwrite_q;
    assign mem_memread    = mem_memread_q;
    assign mem_memwrite   = mem_memwrite_q;
    assign mem_result     = mem_result_q;
    assign mem_store_data = mem_store_data_q;
    assign mem_rd         = mem_rd_q;
    assign hi             = hi_q;
    assign lo             = lo_q;

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM boundary stage of the pipelined CPU, directly downstream of the barrel shifter and ALU. It selects the EX-stage result from the ALU, barrel shifter, HI, or LO, then registers it with its control bits into the EX/MEM pipeline register. It also contains the HI/LO register pair and a sequential 32-iteration shift-add unsigned multiplier (MULTU) that stalls EX while it runs. Flush and downstream stall are honoured.

## Interface
- No parameters; data width fixed at 32, register index at 5.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- ex_valid  in  1  EX holds a valid instruction
- ex_sel  in  2  result select: 0 ALU, 1 shifter, 2 HI (MFHI), 3 LO (MFLO)
- ex_multu  in  1  EX instruction is MULTU
- alu_result  in  32  ALU output
- sht_result  in  32  barrel shifter dataOut
- mul_a, mul_b  in  32 each  MULTU operands (rs, rt)
- ex_rd  in  5  destination register
- ex_regwrite, ex_memread, ex_memwrite  in  1 each  control bits
- ex_store_data  in  32  store data (rt)
- mem_stall  in  1  MEM cannot accept; hold the register
- flush  in  1  kill the instruction in EX and the MULTU in progress
- stall_ex  out  1  hold IF/ID/EX (multiply not finished)
- mem_valid, mem_regwrite, mem_memread, mem_memwrite  out  1 each
- mem_result, mem_store_data  out  32 each
- mem_rd  out  5
- hi, lo  out  32 each  architectural HI/LO

## Operation
- Multiplier FSM, 3 states: IDLE, BUSY, DONE.
  - IDLE: on ex_valid & ex_multu & !flush, latch multiplicand = mul_a and multiplier = mul_b, clear the 64-bit accumulator, count = 0, go to BUSY.
  - BUSY, each cycle: if multiplier[0], add the multiplicand to accumulator[63:32] with a 33-bit sum. Shift {carry, accumulator} right by 1 and shift the multiplier right by 1. count++. After count 31 (32 iterations), go to DONE.
  - DONE: leave when !mem_stall. On that edge write hi = accumulator[63:32] and lo = accumulator[31:0], then go to IDLE.
  - The multiply continues through mem_stall while in BUSY.
- stall_ex = ex_valid & ex_multu & (state != DONE); combinational.
- flush in any state: FSM goes to IDLE and HI/LO are unchanged. A multiply is committed only on the DONE exit edge.
- Pipeline register update, in priority order:
  - flush: mem_valid and all mem control bits cleared.
  - mem_stall: all mem_* outputs hold.
  - stall_ex: bubble inserted; mem_valid and control bits cleared.
  - Otherwise capture:
    - mem_valid = ex_valid; control bits = ex_* & ex_valid.
    - mem_result = mux(ex_sel) of alu_result / sht_result / hi / lo.
    - mem_rd and mem_store_data are passed through.
- A MULTU enters EX/MEM as a valid instruction with regwrite = 0. Decode guarantees this.
- The mem_rd and mem_result data fields may also be cleared on flush and bubble; only the valid and control bits are checked.

## Timing
- Reset (async): state IDLE, count 0, hi = lo = 0, all mem_* outputs 0. stall_ex is then 0 unless ex_valid & ex_multu.
- Non-MULTU instructions: 1-cycle latency, EX inputs to mem_* on the next rising edge.
- MULTU accepted in cycle 0 (IDLE):
  - stall_ex is high in cycle 0 and cycles 1–32 (BUSY), 33 cycles in total.
  - Cycle 33 is DONE: stall_ex low, and the instruction advances on that edge if !mem_stall.
  - hi/lo become visible after that same edge.
- MFHI/MFLO immediately following MULTU enters EX on the commit edge and reads the new value. No forwarding path is needed.
- mem_stall in DONE: the FSM stays in DONE and stall_ex stays low, because the global stall holds EX. The commit waits.
- reset mid-BUSY aborts the multiply; HI/LO return to 0.
- A MULTU held in EX by an earlier mem_stall while the FSM is IDLE still starts; stall_ex asserts.

## Test plan
- Passthrough: ex_valid = 1, ex_sel = 1, sht_result = 0x0000_00F0, ex_rd = 5, regwrite = 1 -> next edge: mem_valid = 1, mem_result = 0x0000_00F0, mem_rd = 5, mem_regwrite = 1.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF -> stall_ex high for exactly 33 cycles, then hi = 0xFFFF_FFFE and lo = 0x0000_0001 after the DONE edge. The next MFHI gives mem_result = 0xFFFF_FFFE.
- MULTU 0x0001_0000 × 0x0001_0000 -> hi = 0x0000_0001, lo = 0; bubbles (mem_valid = 0) appear in EX/MEM during the stall.
- flush at BUSY count 10 -> FSM returns to IDLE next edge and hi/lo keep their prior values. A new MULTU then accepted runs the full 33 stall cycles.
- mem_stall held 3 cycles with a valid ALU result registered -> mem_* unchanged; capture resumes on release. mem_stall asserted in DONE delays the hi/lo commit by the same 3 cycles.
- reset asserted asynchronously mid-BUSY -> all mem_* = 0, hi = lo = 0, FSM IDLE immediately, without waiting for a clock edge.
